// File: rtl/pinza_pkg.sv
// Shared types and constants for the gripper command path.
// State encoding, default duty counts and counter width helper.
package pinza_pkg;

    typedef enum logic [1:0] {
        ST_OPEN    = 2'd0,
        ST_CLOSING = 2'd1,
        ST_CLOSED  = 2'd2,
        ST_OPENING = 2'd3
    } state_t;

    localparam int unsigned DEF_DUTY_OPEN   = 25_000;
    localparam int unsigned DEF_DUTY_CLOSED = 100_000;
    localparam int unsigned DEF_STEP        = 1_000;

    // Bits needed to hold 0..n-1, never less than one.
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Button conditioner: 2-FF sync, stable-time debounce and a
// one-cycle press pulse on each debounced 1->0 transition.
module btn_debounce
    import pinza_pkg::*;
#(
    parameter int unsigned CLK_HZ      = 50_000_000,
    parameter int unsigned DEBOUNCE_MS = 20
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_n_i,
    output logic press_o
);

    localparam int unsigned DEB_CYC = (CLK_HZ / 1000) * DEBOUNCE_MS;
    localparam int unsigned W       = cnt_w(DEB_CYC);
    localparam logic [W-1:0] CNT_LAST = W'(DEB_CYC - 1);

    logic         sync1_q;
    logic         sync2_q;
    logic         lvl_q;
    logic         lvl_d;
    logic         press_q;
    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Count while the synced input disagrees; flip once it held long enough.
    always_comb begin
        lvl_d = lvl_q;
        cnt_d = '0;
        if (sync2_q != lvl_q) begin
            if (cnt_q == CNT_LAST) begin
                lvl_d = sync2_q;
            end else begin
                cnt_d = cnt_q + W'(1);
            end
        end
    end

    // Synchronizer, debounce state and registered press pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            lvl_q   <= 1'b1;
            cnt_q   <= '0;
            press_q <= 1'b0;
        end else begin
            sync1_q <= btn_n_i;
            sync2_q <= sync1_q;
            lvl_q   <= lvl_d;
            cnt_q   <= cnt_d;
            press_q <= lvl_q & ~lvl_d;
        end
    end

    assign press_o = press_q;

endmodule

// File: rtl/pinza_cmd_ramp.sv
// Gripper command stage: press toggles open/closed, duty ramps
// toward the target once per PWM frame with no overshoot.
module pinza_cmd_ramp
    import pinza_pkg::*;
#(
    parameter int unsigned CLK_HZ      = 50_000_000,
    parameter int unsigned FRAME_HZ    = 50,
    parameter int unsigned DEBOUNCE_MS = 20,
    parameter int unsigned DUTY_OPEN   = DEF_DUTY_OPEN,
    parameter int unsigned DUTY_CLOSED = DEF_DUTY_CLOSED,
    parameter int unsigned STEP        = DEF_STEP
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        btn_n,
    output logic [31:0] duty,
    output logic        frame_tick,
    output logic        moving,
    output logic        closed
);

    localparam int unsigned FRAME_CYC = CLK_HZ / FRAME_HZ;
    localparam int unsigned FW        = cnt_w(FRAME_CYC);
    localparam logic [FW-1:0] F_LAST  = FW'(FRAME_CYC - 1);
    localparam logic [31:0] D_OPEN    = 32'(DUTY_OPEN);
    localparam logic [31:0] D_CLOSED  = 32'(DUTY_CLOSED);
    localparam logic [32:0] STEP33    = 33'(STEP);

    logic          press;
    logic [FW-1:0] frame_q;
    logic [FW-1:0] frame_d;
    logic          tick_q;
    state_t        state_q;
    state_t        state_d;
    logic [31:0]   target_q;
    logic [31:0]   target_d;
    logic [31:0]   duty_q;
    logic [31:0]   duty_d;
    logic          moving_q;
    logic          closed_q;
    logic [32:0]   up;
    logic [32:0]   dn;
    logic [32:0]   tgt33;

    btn_debounce #(
        .CLK_HZ      (CLK_HZ),
        .DEBOUNCE_MS (DEBOUNCE_MS)
    ) u_deb (
        .clk     (clk),
        .rst     (rst),
        .btn_n_i (btn_n),
        .press_o (press)
    );

    // Free-running frame counter, wraps after FRAME_CYC cycles.
    always_comb begin
        frame_d = (frame_q == F_LAST) ? '0 : frame_q + FW'(1);
    end

    // Tick is high while the counter sits on its last value.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            frame_q <= '0;
            tick_q  <= 1'b0;
        end else begin
            frame_q <= frame_d;
            tick_q  <= (frame_d == F_LAST);
        end
    end

    // One bounded step toward the current target, in 33 bits.
    always_comb begin
        up     = {1'b0, duty_q} + STEP33;
        dn     = {1'b0, duty_q} - STEP33;
        tgt33  = {1'b0, target_q};
        duty_d = duty_q;
        if (tick_q) begin
            if (duty_q < target_q) begin
                duty_d = (up > tgt33) ? target_q : up[31:0];
            end else if (duty_q > target_q) begin
                duty_d = (dn[32] || dn < tgt33) ? target_q : dn[31:0];
            end
        end
    end

    // Press toggles direction; arrival settles the state.
    always_comb begin
        state_d  = state_q;
        target_d = target_q;
        unique case (state_q)
            ST_OPEN: begin
                if (press) begin
                    state_d  = ST_CLOSING;
                    target_d = D_CLOSED;
                end
            end
            ST_CLOSING: begin
                if (press) begin
                    state_d  = ST_OPENING;
                    target_d = D_OPEN;
                end else if (duty_q == D_CLOSED) begin
                    state_d = ST_CLOSED;
                end
            end
            ST_CLOSED: begin
                if (press) begin
                    state_d  = ST_OPENING;
                    target_d = D_OPEN;
                end
            end
            ST_OPENING: begin
                if (press) begin
                    state_d  = ST_CLOSING;
                    target_d = D_CLOSED;
                end else if (duty_q == D_OPEN) begin
                    state_d = ST_OPEN;
                end
            end
        endcase
    end

    // State, target, duty and status flags, all registered.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_OPEN;
            target_q <= D_OPEN;
            duty_q   <= D_OPEN;
            moving_q <= 1'b0;
            closed_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            target_q <= target_d;
            duty_q   <= duty_d;
            moving_q <= (duty_d != target_d);
            closed_q <= (target_d == D_CLOSED);
        end
    end

    assign duty       = duty_q;
    assign frame_tick = tick_q;
    assign moving     = moving_q;
    assign closed     = closed_q;

endmodule

// File: tb/tb_pinza_cmd_ramp.sv
// Directed bench for pinza_cmd_ramp at reduced clock rates.
// Expected values are hand-derived from the command/ramp rules.
module tb_pinza_cmd_ramp;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        btn_n = 1'b1;
    logic [31:0] duty;
    logic        frame_tick;
    logic        moving;
    logic        closed;

    int n_cmp = 0;
    int n_bad = 0;

    int up_exp[8] = '{35, 45, 55, 65, 75, 85, 95, 100};
    int dn_exp[8] = '{90, 80, 70, 60, 50, 40, 30, 25};
    int rv_up[4]  = '{35, 45, 55, 65};
    int rv_dn[4]  = '{55, 45, 35, 25};

    pinza_cmd_ramp #(
        .CLK_HZ      (1000),
        .FRAME_HZ    (10),
        .DEBOUNCE_MS (5),
        .DUTY_OPEN   (25),
        .DUTY_CLOSED (100),
        .STEP        (10)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .btn_n      (btn_n),
        .duty       (duty),
        .frame_tick (frame_tick),
        .moving     (moving),
        .closed     (closed)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_tick();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!frame_tick && n < 300);
        if (!frame_tick) chk("tick_timeout", 32'd0, 32'd1);
    endtask

    task automatic period(input string tag);
        int n;
        wait_tick();
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!frame_tick && n < 300);
        chk(tag, n, 100);
    endtask

    task automatic press_at(input string tag, input bit sync, input int pre);
        logic old;
        int   n;
        if (sync) wait_tick();
        cyc(pre);
        old   = closed;
        btn_n = 1'b0;
        n     = 0;
        do begin
            @(negedge clk);
            n++;
        end while (closed == old && n < 40);
        chk({tag, "_lat"}, n, 8);
        if (n < 20) cyc(20 - n);
        btn_n = 1'b1;
        cyc(5);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst   = 1'b0;
        btn_n = 1'b1;
        cyc(3);
        chk("rst_duty", duty, 25);
        chk("rst_closed", closed, 0);
        chk("rst_moving", moving, 0);
        chk("rst_tick", frame_tick, 0);
        rst = 1'b1;
        period("period0");

        cyc(2);
        btn_n = 1'b0;
        cyc(3);
        btn_n = 1'b1;
        cyc(20);
        chk("glitch_closed", closed, 0);
        chk("glitch_duty", duty, 25);

        press_at("close", 1'b1, 2);
        chk("close_closed", closed, 1);
        for (int i = 0; i < 8; i++) begin
            wait_tick();
            @(negedge clk);
            chk($sformatf("up%0d", i), duty, up_exp[i]);
            cyc(50);
            chk($sformatf("up_hold%0d", i), duty, up_exp[i]);
        end
        chk("closed_moving", moving, 0);
        chk("closed_closed", closed, 1);

        press_at("open", 1'b1, 2);
        chk("open_closed", closed, 0);
        chk("open_moving", moving, 1);
        for (int i = 0; i < 8; i++) begin
            wait_tick();
            @(negedge clk);
            chk($sformatf("dn%0d", i), duty, dn_exp[i]);
        end
        chk("open_moving_end", moving, 0);

        press_at("rv_close", 1'b1, 2);
        for (int i = 0; i < 4; i++) begin
            wait_tick();
            @(negedge clk);
            chk($sformatf("rv_up%0d", i), duty, rv_up[i]);
        end
        press_at("rv_open", 1'b0, 0);
        chk("rv_closed", closed, 0);
        chk("rv_duty_held", duty, 65);
        for (int i = 0; i < 4; i++) begin
            wait_tick();
            @(negedge clk);
            chk($sformatf("rv_dn%0d", i), duty, rv_dn[i]);
        end
        chk("rv_moving_end", moving, 0);
        chk("rv_closed_end", closed, 0);

        press_at("coll", 1'b1, 93);
        chk("coll_duty", duty, 25);
        chk("coll_closed", closed, 1);
        chk("coll_moving", moving, 1);
        wait_tick();
        @(negedge clk);
        chk("coll_next", duty, 35);

        wait_tick();
        @(negedge clk);
        chk("pre_rst_duty", duty, 45);
        cyc(10);
        rst = 1'b0;
        #1;
        chk("mid_rst_duty", duty, 25);
        chk("mid_rst_closed", closed, 0);
        chk("mid_rst_moving", moving, 0);
        chk("mid_rst_tick", frame_tick, 0);
        cyc(3);
        rst = 1'b1;
        period("period1");
        @(negedge clk);
        chk("post_rst_duty", duty, 25);

        wait_tick();
        cyc(2);
        btn_n = 1'b0;
        cyc(1000);
        chk("hold_closed", closed, 1);
        chk("hold_duty", duty, 100);
        chk("hold_moving", moving, 0);
        btn_n = 1'b1;
        cyc(50);
        chk("rel_closed", closed, 1);
        chk("rel_duty", duty, 100);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
